// File: rtl/expr.sv
// Serial recogniser for expressions of the form D(OD)*, one ASCII character per clock.
// Moore FSM: out is high only while the characters since the last clr form a complete expression.
module expr (
  input  logic       clk,
  input  logic       clr,
  input  logic [7:0] in,
  output logic       out,
  output logic [2:0] s
);

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    DIGIT = 3'd1,
    OP    = 3'd2,
    ERR   = 3'd3
  } state_t;

  // Power-up value keeps simulation defined before the first clr.
  state_t st_reg = INIT;
  state_t st_next;

  logic is_d;
  logic is_o;

  // Unknown bytes (X/Z) fall through the if-tests below and are treated as "other".
  assign is_d = (in >= 8'h30) && (in <= 8'h39);
  assign is_o = (in == 8'h2B) || (in == 8'h2A);

  always_ff @(posedge clk) begin
    if (clr) begin
      st_reg <= INIT;
    end else begin
      st_reg <= st_next;
    end
  end

  always_comb begin
    st_next = ERR;
    case (st_reg)
      INIT: begin
        if (is_d) st_next = DIGIT;
        else      st_next = ERR;
      end
      DIGIT: begin
        if (is_o) st_next = OP;
        else      st_next = ERR;
      end
      OP: begin
        if (is_d) st_next = DIGIT;
        else      st_next = ERR;
      end
      ERR:     st_next = ERR;
      default: st_next = ERR;
    endcase
  end

  assign out = (st_reg == DIGIT);
  assign s   = st_reg;

endmodule

// File: tb/tb_expr.sv
// Table-driven bench for the expr recogniser; each row is one clock edge with its
// clr/in stimulus and the hand-computed state/out expected after that edge.
module tb_expr;

  logic       clk;
  logic       clr;
  logic [7:0] in;
  logic       out;
  logic [2:0] s;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       clr;
    logic [7:0] ch;
    logic [2:0] exp_s;
    logic       exp_out;
    string      name;
  } vec_t;

  vec_t vecs[$];

  expr dut (
    .clk (clk),
    .clr (clr),
    .in  (in),
    .out (out),
    .s   (s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic c, input logic [7:0] ch,
                              input logic [2:0] es, input logic eo, input string nm);
    vec_t v;
    v.clr = c; v.ch = ch; v.exp_s = es; v.exp_out = eo; v.name = nm;
    return v;
  endfunction

  task automatic check(input string nm, input logic [2:0] es, input logic eo);
    checks++;
    if (s !== es || out !== eo) begin
      failures++;
      $display("FAIL %s: got s=%0d out=%0b, expected s=%0d out=%0b", nm, s, out, es, eo);
    end else begin
      $display("ok   %s: s=%0d out=%0b", nm, s, out);
    end
  endtask

  // Drive on the falling edge, sample 1ns after the rising edge.
  task automatic step(input logic c, input logic [7:0] ch,
                      input logic [2:0] es, input logic eo, input string nm);
    @(negedge clk);
    clr = c;
    in  = ch;
    @(posedge clk);
    #1;
    check(nm, es, eo);
  endtask

  initial begin
    clr = 1'b0;
    in  = 8'h00;

    vecs.push_back(mk(1'b1, 8'h00, 3'd0, 1'b0, "reset"));
    vecs.push_back(mk(1'b0, "1",   3'd1, 1'b1, "basic_1"));
    vecs.push_back(mk(1'b0, "+",   3'd2, 1'b0, "basic_plus"));
    vecs.push_back(mk(1'b0, "3",   3'd1, 1'b1, "basic_3"));
    vecs.push_back(mk(1'b0, "*",   3'd2, 1'b0, "basic_star"));
    vecs.push_back(mk(1'b0, "*",   3'd3, 1'b0, "double_op"));
    vecs.push_back(mk(1'b0, "0",   3'd3, 1'b0, "err_sticky"));
    vecs.push_back(mk(1'b1, "7",   3'd0, 1'b0, "clr_from_err"));
    vecs.push_back(mk(1'b0, "0",   3'd1, 1'b1, "digit_after_clr"));
    vecs.push_back(mk(1'b0, "1",   3'd3, 1'b0, "digit_digit"));
    vecs.push_back(mk(1'b1, 8'h00, 3'd0, 1'b0, "clr_a"));
    vecs.push_back(mk(1'b0, "+",   3'd3, 1'b0, "leading_op"));
    vecs.push_back(mk(1'b1, 8'h00, 3'd0, 1'b0, "clr_b"));
    vecs.push_back(mk(1'b0, 8'h41, 3'd3, 1'b0, "junk_A"));
    vecs.push_back(mk(1'b1, 8'h00, 3'd0, 1'b0, "clr_c"));
    vecs.push_back(mk(1'b0, 8'h2F, 3'd3, 1'b0, "below_0"));
    vecs.push_back(mk(1'b1, 8'h00, 3'd0, 1'b0, "clr_d"));
    vecs.push_back(mk(1'b0, 8'h3A, 3'd3, 1'b0, "above_9"));
    vecs.push_back(mk(1'b1, 8'h00, 3'd0, 1'b0, "clr_e"));
    vecs.push_back(mk(1'b0, "9",   3'd1, 1'b1, "digit_9"));
    vecs.push_back(mk(1'b0, 8'h2C, 3'd3, 1'b0, "comma_after_digit"));
    vecs.push_back(mk(1'b1, 8'h00, 3'd0, 1'b0, "clr_f"));
    vecs.push_back(mk(1'b0, "0",   3'd1, 1'b1, "digit_0"));
    vecs.push_back(mk(1'b0, "*",   3'd2, 1'b0, "op_star"));
    vecs.push_back(mk(1'b0, "9",   3'd1, 1'b1, "op_then_9"));
    vecs.push_back(mk(1'b0, "+",   3'd2, 1'b0, "op_plus"));
    vecs.push_back(mk(1'b0, 8'h2B, 3'd3, 1'b0, "trailing_then_op"));

    // Power-up value before any clr.
    #1;
    check("power_up", 3'd0, 1'b0);

    foreach (vecs[i]) begin
      step(vecs[i].clr, vecs[i].ch, vecs[i].exp_s, vecs[i].exp_out, vecs[i].name);
    end

    // clr wins over a valid digit for as long as it is held, then recognition resumes.
    step(1'b1, "5", 3'd0, 1'b0, "clr_prio_1");
    step(1'b1, "5", 3'd0, 1'b0, "clr_prio_2");
    step(1'b0, "5", 3'd1, 1'b1, "clr_release");
    step(1'b0, "+", 3'd2, 1'b0, "resume_op");
    step(1'b1, "+", 3'd0, 1'b0, "clr_from_op");
    step(1'b0, "8", 3'd1, 1'b1, "resume_digit");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
